// File: rtl/serial_mod_pkg.sv
// Shared constants, state type and residue reduction
// for the serial divisibility checker.
package serial_mod_pkg;

    localparam int DIVISOR_MIN = 2;
    localparam int DIVISOR_MAX = 255;
    localparam int NCH_MAX     = 8;

    // Wide enough for any intermediate < 2*DIVISOR_MAX.
    localparam int XW = 9;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    function automatic logic [XW-1:0] mod_reduce(
        input logic [XW-1:0] x,
        input logic [XW-1:0] d
    );
        return (x >= d) ? x - d : x;
    endfunction

endpackage

// File: rtl/serial_mod_checker_if.sv
// Input/output bundle of the serial divisibility checker.
// The source side drives master; the checker is the slave.
interface serial_mod_checker_if #(
    parameter int NCH = 1,
    parameter int RW  = 3
);

    logic              in_valid;
    logic              start;
    logic              clear;
    logic [NCH-1:0]    in_bit;
    logic              seen;
    logic [NCH-1:0]    divisible;
    logic [NCH*RW-1:0] remainder;

    modport master (
        output in_valid,
        output start,
        output clear,
        output in_bit,
        input  seen,
        input  divisible,
        input  remainder
    );

    modport slave (
        input  in_valid,
        input  start,
        input  clear,
        input  in_bit,
        output seen,
        output divisible,
        output remainder
    );

endinterface

// File: rtl/serial_mod_lane.sv
// One channel: residue register and next-residue logic
// for either bit order.
module serial_mod_lane
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR   = 5,
    parameter bit LSB_FIRST = 1'b0,
    parameter int RW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          accept,
    input  logic          restart,
    input  logic [RW-1:0] p,
    input  logic          b,
    output logic [RW-1:0] rem
);

    localparam logic [XW-1:0] D = XW'(DIVISOR);

    logic [XW-1:0] base;
    logic [XW-1:0] msb_sum;
    logic [XW-1:0] lsb_sum;
    logic [XW-1:0] nxt;
    logic          unused_hi;

    assign base    = restart ? '0 : XW'(rem);
    assign msb_sum = (base << 1) | XW'(b);
    // b*p reduces to masking p with the incoming bit.
    assign lsb_sum = base + XW'({RW{b}} & p);
    assign nxt     = mod_reduce(LSB_FIRST ? lsb_sum : msb_sum, D);

    assign unused_hi = ^nxt[XW-1:RW];

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
        end else if (clear) begin
            rem <= '0;
        end else if (accept) begin
            rem <= nxt[RW-1:0];
        end
    end

endmodule

// File: rtl/serial_mod_checker.sv
// NCH lock-stepped serial streams, each tracked modulo DIVISOR;
// owns framing state, the shared power-of-two register and packing.
module serial_mod_checker
    import serial_mod_pkg::*;
#(
    parameter int DIVISOR   = 5,
    parameter int NCH       = 1,
    parameter bit LSB_FIRST = 1'b0,
    parameter int RW        = $clog2(DIVISOR)
) (
    input  logic                clk,
    input  logic                rst,
    serial_mod_checker_if.slave bus
);

    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_div
        $error("serial_mod_checker: DIVISOR out of range");
    end
    if (NCH < 1 || NCH > NCH_MAX) begin : g_bad_nch
        $error("serial_mod_checker: NCH out of range");
    end

    state_t        state_q;
    state_t        state_d;
    logic [RW-1:0] pow_q;
    logic [RW-1:0] p;
    logic [XW-1:0] pow_nxt;
    logic          restart;
    logic          accept;
    logic          unused_pow;
    logic [RW-1:0] rem_w [NCH];

    // A bit starts a new number on start or when nothing is held yet.
    assign restart = bus.start | (state_q == ST_IDLE);
    assign accept  = bus.in_valid & ~bus.clear;
    assign p       = restart ? RW'(1) : pow_q;
    assign pow_nxt = mod_reduce(XW'(p) << 1, XW'(DIVISOR));

    assign unused_pow = ^pow_nxt[XW-1:RW];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            bus.clear: state_d = ST_IDLE;
            accept:    state_d = ST_RUN;
            default:   state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pow_q <= RW'(1);
        end else if (bus.clear) begin
            pow_q <= RW'(1);
        end else if (accept) begin
            pow_q <= pow_nxt[RW-1:0];
        end
    end

    assign bus.seen = (state_q == ST_RUN);

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        serial_mod_lane #(
            .DIVISOR   (DIVISOR),
            .LSB_FIRST (LSB_FIRST),
            .RW        (RW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (bus.clear),
            .accept  (accept),
            .restart (restart),
            .p       (p),
            .b       (bus.in_bit[i]),
            .rem     (rem_w[i])
        );

        assign bus.remainder[i*RW +: RW] = rem_w[i];
        assign bus.divisible[i] =
            (state_q == ST_RUN) && (rem_w[i] == '0);
    end

endmodule

// File: tb/tb_serial_mod_checker.sv
// Self-checking bench: several checker configurations against
// an arithmetic reference model of the streamed values.
module tb_serial_mod_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_mod_checker_if #(.NCH(1), .RW(3)) i5m ();
    serial_mod_checker_if #(.NCH(1), .RW(3)) i5l ();
    serial_mod_checker_if #(.NCH(2), .RW(2)) i3 ();
    serial_mod_checker_if #(.NCH(1), .RW(1)) i2 ();
    serial_mod_checker_if #(.NCH(1), .RW(8)) i255 ();

    serial_mod_checker #(.DIVISOR(5), .NCH(1), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .bus(i5m.slave));
    serial_mod_checker #(.DIVISOR(5), .NCH(1), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .bus(i5l.slave));
    serial_mod_checker #(.DIVISOR(3), .NCH(2), .LSB_FIRST(1'b0)) dut_3 (
        .clk(clk), .rst(rst), .bus(i3.slave));
    serial_mod_checker #(.DIVISOR(2), .NCH(1), .LSB_FIRST(1'b0)) dut_2 (
        .clk(clk), .rst(rst), .bus(i2.slave));
    serial_mod_checker #(.DIVISOR(255), .NCH(1), .LSB_FIRST(1'b0)) dut_255 (
        .clk(clk), .rst(rst), .bus(i255.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        i5m.in_valid = 0; i5m.start = 0; i5m.clear = 0; i5m.in_bit = '0;
        i5l.in_valid = 0; i5l.start = 0; i5l.clear = 0; i5l.in_bit = '0;
        i3.in_valid = 0; i3.start = 0; i3.clear = 0; i3.in_bit = '0;
        i2.in_valid = 0; i2.start = 0; i2.clear = 0; i2.in_bit = '0;
        i255.in_valid = 0; i255.start = 0; i255.clear = 0; i255.in_bit = '0;
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1;
        tick();
        tick();
        total++;
        if (i5m.seen !== 1'b0) begin
            bad++; $display("FAIL reset_seen got=%0b exp=0", i5m.seen);
        end
        total++;
        if (i5m.divisible !== 1'b0) begin
            bad++; $display("FAIL reset_div got=%0b exp=0", i5m.divisible);
        end
        total++;
        if (i5m.remainder !== 3'd0) begin
            bad++; $display("FAIL reset_rem got=%0d exp=0", i5m.remainder);
        end
        total++;
        if (i5l.remainder !== 3'd0 || dut_l.pow_q !== 3'd1) begin
            bad++; $display("FAIL reset_lsb rem=%0d pow=%0d exp 0/1",
                            i5l.remainder, dut_l.pow_q);
        end
        total++;
        if (i3.divisible !== 2'b00 || i3.remainder !== 4'd0) begin
            bad++; $display("FAIL reset_d3 div=%b rem=%h exp 00/0",
                            i3.divisible, i3.remainder);
        end
        total++;
        if (i255.remainder !== 8'd0 || i255.seen !== 1'b0) begin
            bad++; $display("FAIL reset_d255 rem=%0d seen=%0b exp 0/0",
                            i255.remainder, i255.seen);
        end
        rst = 0;
    endtask

    task automatic test_msb();
        int bits[4] = '{1, 0, 1, 0};
        int er[4]   = '{1, 2, 0, 0};
        int ed[4]   = '{0, 0, 1, 1};
        int r;
        bit sn;
        bit v, st, b;
        for (int k = 0; k < 4; k++) begin
            i5m.in_valid = 1;
            i5m.start = (k == 0);
            i5m.in_bit = 1'(bits[k]);
            tick();
            total++;
            if (i5m.remainder !== 3'(er[k]) || i5m.divisible !== 1'(ed[k])
                || i5m.seen !== 1'b1) begin
                bad++; $display("FAIL msb_seq k=%0d rem=%0d div=%0b seen=%0b exp %0d/%0d/1",
                                k, i5m.remainder, i5m.divisible, i5m.seen, er[k], ed[k]);
            end
        end
        r = 0;
        sn = 1;
        for (int k = 0; k < 40; k++) begin
            v = ($urandom % 4) != 0;
            st = ($urandom % 8) == 0;
            b = 1'($urandom);
            i5m.in_valid = v;
            i5m.start = st;
            i5m.in_bit = b;
            if (v) begin
                if (st || !sn) r = 0;
                r = (2 * r + int'(b)) % 5;
                sn = 1;
            end
            tick();
            total++;
            if (i5m.remainder !== 3'(r) || i5m.divisible !== (sn && r == 0)
                || i5m.seen !== sn) begin
                bad++; $display("FAIL msb_rand k=%0d rem=%0d div=%0b exp %0d/%0b",
                                k, i5m.remainder, i5m.divisible, r, (sn && r == 0));
            end
        end
        i5m.in_valid = 0;
        i5m.start = 0;
    endtask

    task automatic test_lsb();
        int bits[4] = '{1, 0, 1, 0};
        int er[4]   = '{1, 1, 0, 0};
        int ep[4]   = '{2, 4, 3, 1};
        longint unsigned val;
        int n;
        bit v, st, b;
        for (int k = 0; k < 4; k++) begin
            i5l.in_valid = 1;
            i5l.start = (k == 0);
            i5l.in_bit = 1'(bits[k]);
            tick();
            total++;
            if (i5l.remainder !== 3'(er[k]) || dut_l.pow_q !== 3'(ep[k])) begin
                bad++; $display("FAIL lsb_seq k=%0d rem=%0d pow=%0d exp %0d/%0d",
                                k, i5l.remainder, dut_l.pow_q, er[k], ep[k]);
            end
        end
        total++;
        if (i5l.divisible !== 1'b1) begin
            bad++; $display("FAIL lsb_div5 got=%0b exp=1", i5l.divisible);
        end
        val = 0;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            v = ($urandom % 4) != 0;
            st = ($urandom % 8) == 0 || n >= 50;
            b = 1'($urandom);
            i5l.in_valid = v;
            i5l.start = st;
            i5l.in_bit = b;
            if (v) begin
                if (st) begin
                    val = 0;
                    n = 0;
                end
                if (b) val = val + (64'd1 << n);
                n++;
            end
            tick();
            total++;
            if (i5l.remainder !== 3'(val % 5)) begin
                bad++; $display("FAIL lsb_rand k=%0d rem=%0d exp=%0d",
                                k, i5l.remainder, val % 5);
            end
        end
        i5l.in_valid = 0;
        i5l.start = 0;
    endtask

    task automatic test_gaps();
        int b0[3] = '{1, 1, 0};
        int b1[3] = '{1, 1, 1};
        int v0, v1, gaps;
        logic [3:0] exp_rem;
        v0 = 0;
        v1 = 0;
        for (int k = 0; k < 3; k++) begin
            i3.in_valid = 1;
            i3.start = (k == 0);
            i3.in_bit = {1'(b1[k]), 1'(b0[k])};
            v0 = 2 * v0 + b0[k];
            v1 = 2 * v1 + b1[k];
            tick();
            exp_rem = {2'(v1 % 3), 2'(v0 % 3)};
            gaps = 1 + int'($urandom % 3);
            for (int g = 0; g <= gaps; g++) begin
                total++;
                if (i3.remainder !== exp_rem || i3.seen !== 1'b1) begin
                    bad++; $display("FAIL gap_hold k=%0d g=%0d rem=%h exp=%h",
                                    k, g, i3.remainder, exp_rem);
                end
                i3.in_valid = 0;
                i3.start = ($urandom % 2) == 1;
                i3.in_bit = 2'($urandom);
                if (g < gaps) tick();
            end
        end
        i3.start = 0;
        total++;
        if (i3.remainder !== 4'b0100 || i3.divisible !== 2'b01) begin
            bad++; $display("FAIL gap_final rem=%b div=%b exp 0100/01",
                            i3.remainder, i3.divisible);
        end
    endtask

    task automatic test_back_to_back();
        int bits[5] = '{1, 0, 1, 1, 1};
        int sts[5]  = '{1, 0, 0, 1, 0};
        int er[5]   = '{1, 2, 0, 1, 3};
        int ed[5]   = '{0, 0, 1, 0, 0};
        for (int k = 0; k < 5; k++) begin
            i5m.in_valid = 1;
            i5m.start = 1'(sts[k]);
            i5m.in_bit = 1'(bits[k]);
            tick();
            total++;
            if (i5m.remainder !== 3'(er[k]) || i5m.divisible !== 1'(ed[k])) begin
                bad++; $display("FAIL b2b k=%0d rem=%0d div=%0b exp %0d/%0d",
                                k, i5m.remainder, i5m.divisible, er[k], ed[k]);
            end
        end
        i5m.in_valid = 0;
        i5m.start = 0;
    endtask

    task automatic test_rst_clear();
        i5m.in_valid = 1;
        i5m.start = 1;
        i5m.in_bit = 1;
        tick();
        i5m.start = 0;
        tick();
        total++;
        if (i5m.remainder !== 3'd3) begin
            bad++; $display("FAIL pre_rst rem=%0d exp=3", i5m.remainder);
        end
        rst = 1;
        tick();
        rst = 0;
        total++;
        if (i5m.seen !== 1'b0 || i5m.remainder !== 3'd0 || i5m.divisible !== 1'b0) begin
            bad++; $display("FAIL mid_rst seen=%0b rem=%0d div=%0b exp 0/0/0",
                            i5m.seen, i5m.remainder, i5m.divisible);
        end
        i5m.start = 1;
        i5m.in_bit = 1;
        tick();
        i5m.start = 0;
        i5m.clear = 1;
        tick();
        total++;
        if (i5m.seen !== 1'b0 || i5m.remainder !== 3'd0 || i5m.divisible !== 1'b0) begin
            bad++; $display("FAIL clear seen=%0b rem=%0d div=%0b exp 0/0/0",
                            i5m.seen, i5m.remainder, i5m.divisible);
        end
        i5m.clear = 0;
        i5m.in_bit = 0;
        tick();
        total++;
        if (i5m.seen !== 1'b1 || i5m.remainder !== 3'd0 || i5m.divisible !== 1'b1) begin
            bad++; $display("FAIL after_clear seen=%0b rem=%0d div=%0b exp 1/0/1",
                            i5m.seen, i5m.remainder, i5m.divisible);
        end
        i5m.in_valid = 0;
    endtask

    task automatic test_edges();
        logic [63:0] val;
        bit b;
        for (int k = 0; k < 16; k++) begin
            b = 1'($urandom);
            i2.in_valid = 1;
            i2.start = (k == 0);
            i2.in_bit = b;
            tick();
            total++;
            if (i2.remainder !== b || i2.divisible !== !b) begin
                bad++; $display("FAIL d2 k=%0d rem=%0b div=%0b exp %0b/%0b",
                                k, i2.remainder, i2.divisible, b, !b);
            end
        end
        i2.in_valid = 0;
        i2.start = 0;
        val = '0;
        for (int k = 0; k < 64; k++) begin
            b = 1'($urandom);
            i255.in_valid = 1;
            i255.start = (k == 0);
            i255.in_bit = b;
            val = {val[62:0], b};
            tick();
            total++;
            if (i255.remainder !== 8'(val % 255)
                || i255.divisible !== ((val % 255) == 0)) begin
                bad++; $display("FAIL d255 k=%0d rem=%0d exp=%0d",
                                k, i255.remainder, val % 255);
            end
        end
        i255.in_valid = 0;
        i255.start = 0;
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_gaps();
        test_back_to_back();
        test_rst_clear();
        test_edges();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
